// File: rtl/graphics_pkg.sv
// Shared pixel beat format for the graphics primitive streams.
package graphics_pkg;

   localparam int unsigned X_WIDTH     = 12;
   localparam int unsigned Y_WIDTH     = 12;
   localparam int unsigned COLOR_WIDTH = 8;

   typedef struct packed {
      logic [X_WIDTH-1:0]     x;
      logic [Y_WIDTH-1:0]     y;
      logic [COLOR_WIDTH-1:0] color;
   } pixel_t;

   localparam int unsigned ST_DATA_WIDTH = $bits(pixel_t);

endpackage

// File: rtl/graphics_pixel_writer.sv
// Pixel stream sink: buffers beats in a small FIFO, clips to the visible area
// and issues one Avalon-MM word write per visible pixel into the frame buffer.
module graphics_pixel_writer
   import graphics_pkg::*;
#(
   parameter int unsigned H_RES         = 640,
   parameter int unsigned V_RES         = 480,
   parameter int unsigned FB_BASE       = 0,
   parameter int unsigned FB_ADDR_WIDTH = 19,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ST_DATA_WIDTH-1:0] st_data,
   input  logic                     st_valid,
   output logic                     st_ready,
   output logic [FB_ADDR_WIDTH-1:0] mm_fb_address,
   output logic [COLOR_WIDTH-1:0]   mm_fb_writedata,
   output logic                     mm_fb_write,
   input  logic                     mm_fb_waitrequest,
   output logic                     idle
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PROD_W = Y_WIDTH + 32;
   localparam int unsigned SUM_W  = PROD_W + 1;

   pixel_t             fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;

   pixel_t             in_pix;
   pixel_t             head;
   logic               push;
   logic               pop;
   logic               or_free;
   logic               in_range;
   logic [PROD_W-1:0]  row_offset;
   logic [SUM_W-1:0]   lin_addr;

   assign in_pix = pixel_t'(st_data);

   // Handshake and pop decisions; ready comes only from registered occupancy.
   always_comb begin
      st_ready = (count != CNT_W'(FIFO_DEPTH));
      or_free  = !mm_fb_write || !mm_fb_waitrequest;
      push     = st_valid && st_ready;
      pop      = (count != '0) && or_free;
      idle     = (count == '0) && !mm_fb_write;
   end

   // Clip test and linear address of the FIFO head, full-width product first.
   always_comb begin
      head       = fifo_mem[rd_ptr];
      in_range   = (32'(head.x) < H_RES) && (32'(head.y) < V_RES);
      row_offset = PROD_W'(head.y) * PROD_W'(H_RES);
      lin_addr   = SUM_W'(FB_BASE) + SUM_W'(row_offset) + SUM_W'(head.x);
   end

   // FIFO storage; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= in_pix;
      end
   end

   // FIFO pointers and occupancy; power-of-2 depth lets pointers wrap naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Output register: load visible pixels, drop clipped ones, hold while stalled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mm_fb_write     <= 1'b0;
         mm_fb_address   <= '0;
         mm_fb_writedata <= '0;
      end else if (or_free) begin
         if (pop && in_range) begin
            mm_fb_write     <= 1'b1;
            mm_fb_address   <= FB_ADDR_WIDTH'(lin_addr);
            mm_fb_writedata <= head.color;
         end else begin
            mm_fb_write <= 1'b0;
         end
      end
   end

endmodule

// File: doc/graphics_pixel_writer.md
# graphics_pixel_writer

Avalon-ST pixel sink that terminates the pixel streams produced by the graphics primitives (rectangle fill, line and similar) and turns each pixel into a single-word Avalon-MM write into the frame buffer. It buffers incoming pixels in a small FIFO, discards pixels that fall outside the visible area, and computes the linear frame-buffer address. An `idle` flag tells the graphics controller when every accepted pixel has been committed to memory.

## Interface

Parameters:
- `H_RES`, 640: visible width in pixels; also the row pitch in words.
- `V_RES`, 480: visible height in pixels.
- `FB_BASE`, 0: word address of pixel (0,0).
- `FB_ADDR_WIDTH`, 19: width of the MM word address.
- `FIFO_DEPTH`, 4: input FIFO entries; must be a power of 2 and at least 2.

Ports:
- `clk`  in  1: single clock domain.
- `reset`  in  1: asynchronous, active-high reset.
- `st_data`  in  ST_DATA_WIDTH: a `pixel_t` beat carrying fields `x`, `y` and `color` (graphics_pkg).
- `st_valid`  in  1: source presents a beat.
- `st_ready`  out  1: sink can accept a beat.
- `mm_fb_address`  out  FB_ADDR_WIDTH: word address for the write.
- `mm_fb_writedata`  out  COLOR_WIDTH: pixel colour.
- `mm_fb_write`  out  1: write request.
- `mm_fb_waitrequest`  in  1: slave stall.
- `idle`  out  1: FIFO empty and no write pending.

## Operation

- Beat transfer: a beat is accepted on a rising edge where `st_valid && st_ready`. It is pushed into the FIFO tail.
- `st_ready = (count != FIFO_DEPTH)`. It is decoded combinationally from the registered occupancy `count` and does not depend on `st_valid`.
- The FIFO has no bypass. When the FIFO is full, a pop in the same cycle does not raise `st_ready` until the following cycle.
- Output register (OR): holds `mm_fb_address`, `mm_fb_writedata` and `mm_fb_write`. It is considered free when `!mm_fb_write || !mm_fb_waitrequest`.
- Pop rule: when the FIFO is non-empty and the OR is free, the head entry is popped on that edge.
  - In range (`x < H_RES && y < V_RES`): the OR loads address `FB_BASE + y*H_RES + x`, truncated to FB_ADDR_WIDTH, the entry's `color`, and `mm_fb_write <= 1`.
  - Out of range: the entry is discarded. If no new write is loaded, `mm_fb_write <= 0`.
- Completion: when the OR is free and the FIFO is empty, `mm_fb_write <= 0`.
- Stall: while `mm_fb_write && mm_fb_waitrequest`, all OR outputs hold stable and no pop occurs.
- Arithmetic: `y*H_RES` is computed at full product width before the add, with unsigned operands.
- `idle = (count == 0) && !mm_fb_write`.
- Simultaneous push and pop: `count` is unchanged, and the tail and head pointers each advance by one.
- Pointers wrap modulo FIFO_DEPTH.
- The block has no state machine beyond the FIFO and the OR valid bit. Ordering is strictly preserved.

## Timing

- Reset values, applied asynchronously:
  - `count = 0`, pointers = 0.
  - `mm_fb_write = 0`, `mm_fb_address = 0`, `mm_fb_writedata = 0`.
  - As a consequence, `st_ready = 1` and `idle = 1`.
- Reset asserted mid-burst drops `mm_fb_write` immediately, without waiting for a clock edge, and discards all buffered pixels. This is legal only when the slave tolerates an aborted request.
- Latency: a beat accepted at edge E0 produces `mm_fb_write = 1` in the cycle after edge E1, giving 2 edges of latency with no stall.
- Throughput: 1 pixel/clock sustained when `mm_fb_waitrequest = 0`.
- A write completes on the edge where `mm_fb_write && !mm_fb_waitrequest`.
- `idle` rises in the cycle after the last write completes, and only if no beat was accepted meanwhile.

## Test plan

1. **Reset values.** Assert `reset` asynchronously between clock edges -> `st_ready = 1`, `mm_fb_write = 0`, `idle = 1` immediately.
2. **Single pixel.** With H_RES=640 and FB_BASE=0, send x=5, y=2, color=0x3 -> one write with address 1285, data 0x3, two edges after acceptance. `idle` returns to 1 one cycle after the write completes.
3. **Streaming throughput.** Feed a 4×3 rectangle stream, x=10..13, y=20..22, with `waitrequest = 0` -> 12 writes on consecutive cycles. Addresses are 12810–12813, 13450–13453 and 14090–14093, in order.
4. **Backpressure.** Hold `mm_fb_waitrequest = 1` for 10 cycles while streaming -> the OR holds stable and the FIFO fills to 4. `st_ready = 0` from the cycle after `count` reaches 4. No beat is lost or duplicated after release.
5. **Clipping.** Send (639,479), (640,0), (0,480), (0,0) -> exactly two writes: address 307199, then address 0. All four beats are accepted.
6. **Reset mid-operation.** Assert `reset` with 3 entries queued and a write stalled -> `mm_fb_write` falls immediately. After release the block issues no writes until new beats arrive, and `idle = 1`.
